// File: rtl/eth_tx_pkg.sv
// Shared Ethernet transmit constants, FSM state encoding and GMII output bundle.
package eth_tx_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

  // Depth of the input delay line: 7 preamble cycles + 1 SFD cycle.
  localparam int DLY_STAGES = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    IFG
  } state_t;

  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } gmii_tx_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step (reflected polynomial, LSB first).
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte into the low bits, then run eight serial shift/xor steps.
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: preamble/SFD, delayed data, zero pad, CRC-32 FCS, IFG.
module gmii_tx_framer
  import eth_tx_pkg::*;
#(
  parameter int PREAMBLE_LEN = 7,
  parameter int MIN_FRAME    = 60,
  parameter int MAX_FRAME    = 1514,
  parameter int IFG_BYTES    = 12
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_DATA,
  input  logic       IN_DATA_VLD,
  output logic       TX_READY,
  output logic [7:0] GMII_TXD,
  output logic       GMII_TX_EN,
  output logic       GMII_TX_ER,
  output logic       FRAME_DONE,
  output logic       OVERRUN
);

  localparam logic [10:0] MIN_C = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_C = 11'(MAX_FRAME);
  localparam logic [3:0]  PRE_C = 4'(PREAMBLE_LEN);
  localparam logic [7:0]  IFG_C = 8'(IFG_BYTES);

  state_t                        state;
  gmii_tx_t                      tx;
  logic                          vld_q;
  logic                          drop;
  logic [DLY_STAGES:1]           vld_pipe;
  logic [DLY_STAGES:1][7:0]      dat_pipe;
  logic                          tap_vld;
  logic [7:0]                    tap_dat;
  logic                          start;
  logic                          accept;
  logic                          reject;
  logic                          in_vld;
  logic [31:0]                   crc;
  logic [31:0]                   crc_nxt;
  logic [31:0]                   fcs_word;
  logic [7:0]                    crc_feed;
  logic [7:0]                    fcs_byte;
  logic [10:0]                   cnt;
  logic [10:0]                   cnt_inc;
  logic [3:0]                    pre_cnt;
  logic [1:0]                    fcs_idx;
  logic [7:0]                    ifg_cnt;

  assign tap_vld  = vld_pipe[DLY_STAGES];
  assign tap_dat  = dat_pipe[DLY_STAGES];
  assign start    = IN_DATA_VLD & ~vld_q;
  assign accept   = start & (state == IDLE);
  assign reject   = start & (state != IDLE);
  // A rejected frame never enters the delay line, from its first byte on.
  assign in_vld   = IN_DATA_VLD & ~drop & ~reject;

  // Pad cycles feed zeros; the register only advances on DATA/PAD bytes.
  assign crc_feed = (state == DATA && tap_vld) ? tap_dat : 8'h00;
  assign fcs_word = ~crc;
  assign fcs_byte = fcs_word[{fcs_idx, 3'b000} +: 8];
  assign cnt_inc  = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;

  crc32_d8 u_crc (
    .crc_in  (crc),
    .data    (crc_feed),
    .crc_out (crc_nxt)
  );

  // Input edge detect, overrun drop window and the preamble-absorbing delay line.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q    <= 1'b0;
      drop     <= 1'b0;
      vld_pipe <= '0;
      dat_pipe <= '0;
      OVERRUN  <= 1'b0;
    end else begin
      vld_q    <= IN_DATA_VLD;
      OVERRUN  <= reject;
      if (reject)            drop <= 1'b1;
      else if (!IN_DATA_VLD) drop <= 1'b0;
      vld_pipe <= {vld_pipe[DLY_STAGES-1:1], in_vld};
      dat_pipe <= {dat_pipe[DLY_STAGES-1:1], IN_DATA};
    end
  end

  // Framing FSM; every GMII output and status flag is registered here.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      tx         <= '0;
      TX_READY   <= 1'b1;
      FRAME_DONE <= 1'b0;
      crc        <= CRC_INIT;
      cnt        <= '0;
      pre_cnt    <= '0;
      fcs_idx    <= '0;
      ifg_cnt    <= '0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        IDLE: begin
          tx <= '0;
          if (accept) begin
            // First preamble byte goes out on the accepting edge.
            state    <= PREAMBLE;
            tx       <= {PREAMBLE_BYTE, 1'b1, 1'b0};
            pre_cnt  <= 4'd1;
            crc      <= CRC_INIT;
            cnt      <= '0;
            fcs_idx  <= '0;
            TX_READY <= 1'b0;
          end
        end
        PREAMBLE: begin
          if (pre_cnt < PRE_C) begin
            tx      <= {PREAMBLE_BYTE, 1'b1, 1'b0};
            pre_cnt <= pre_cnt + 4'd1;
          end else begin
            tx    <= {SFD_BYTE, 1'b1, 1'b0};
            state <= DATA;
          end
        end
        DATA: begin
          if (tap_vld) begin
            // Oversize frames go out whole but flagged from byte MAX_FRAME+1.
            tx  <= {tap_dat, 1'b1, cnt >= MAX_C};
            crc <= crc_nxt;
            cnt <= cnt_inc;
          end else if (cnt < MIN_C) begin
            tx    <= {8'h00, 1'b1, 1'b0};
            crc   <= crc_nxt;
            cnt   <= cnt_inc;
            state <= PAD;
          end else begin
            tx      <= {fcs_word[7:0], 1'b1, cnt > MAX_C};
            fcs_idx <= 2'd1;
            state   <= FCS;
          end
        end
        PAD: begin
          if (cnt < MIN_C) begin
            tx  <= {8'h00, 1'b1, 1'b0};
            crc <= crc_nxt;
            cnt <= cnt_inc;
          end else begin
            tx      <= {fcs_word[7:0], 1'b1, 1'b0};
            fcs_idx <= 2'd1;
            state   <= FCS;
          end
        end
        FCS: begin
          tx      <= {fcs_byte, 1'b1, cnt > MAX_C};
          fcs_idx <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) begin
            state   <= IFG;
            ifg_cnt <= '0;
          end
        end
        IFG: begin
          tx <= '0;
          if (ifg_cnt == IFG_C) begin
            state      <= IDLE;
            FRAME_DONE <= 1'b1;
            TX_READY   <= 1'b1;
          end else begin
            ifg_cnt <= ifg_cnt + 8'd1;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= '0;
          TX_READY <= 1'b1;
        end
      endcase
    end
  end

  assign GMII_TXD   = tx.txd;
  assign GMII_TX_EN = tx.en;
  assign GMII_TX_ER = tx.er;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed self-checking bench for gmii_tx_framer (wire index m = cycle t+m).
module tb_gmii_tx_framer;
  import eth_tx_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_DATA_VLD = 1'b0;
  logic       TX_READY, GMII_TX_EN, GMII_TX_ER, FRAME_DONE, OVERRUN;
  logic [7:0] GMII_TXD;

  logic [31:0] u_crc_in = 32'h0, u_crc_out;
  logic [7:0]  u_data = 8'h00;

  int n_chk = 0;
  int n_fail = 0;

  logic       in_v     [0:2047];
  logic [7:0] in_dat   [0:2047];
  logic [7:0] cap_txd  [0:2047];
  logic       cap_en   [0:2047];
  logic       cap_er   [0:2047];
  logic       cap_done [0:2047];
  logic       cap_rdy  [0:2047];
  logic       cap_ovr  [0:2047];
  logic [7:0] rs_txd;
  logic       rs_en, rs_er, rs_done, rs_ovr, rs_rdy;

  gmii_tx_framer #(
    .PREAMBLE_LEN (7),
    .MIN_FRAME    (60),
    .MAX_FRAME    (1514),
    .IFG_BYTES    (12)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .IN_DATA     (IN_DATA),
    .IN_DATA_VLD (IN_DATA_VLD),
    .TX_READY    (TX_READY),
    .GMII_TXD    (GMII_TXD),
    .GMII_TX_EN  (GMII_TX_EN),
    .GMII_TX_ER  (GMII_TX_ER),
    .FRAME_DONE  (FRAME_DONE),
    .OVERRUN     (OVERRUN)
  );

  crc32_d8 u_crc_unit (
    .crc_in  (u_crc_in),
    .data    (u_data),
    .crc_out (u_crc_out)
  );

  always #4 CLK = ~CLK;

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic clear_in();
    for (int i = 0; i < 2048; i++) begin
      in_v[i]   = 1'b0;
      in_dat[i] = 8'h00;
    end
  endtask

  // Drive in_v/in_dat[m] before edge t+m, capture wire cycle t+m+1 at the next negedge.
  // Optional reset injection right after capturing index rst_at.
  task automatic run_seq(input int cycles, input int rst_at);
    for (int m = 0; m < cycles; m++) begin
      IN_DATA_VLD = in_v[m];
      IN_DATA     = in_dat[m];
      @(posedge CLK);
      @(negedge CLK);
      cap_txd[m+1]  = GMII_TXD;
      cap_en[m+1]   = GMII_TX_EN;
      cap_er[m+1]   = GMII_TX_ER;
      cap_done[m+1] = FRAME_DONE;
      cap_rdy[m+1]  = TX_READY;
      cap_ovr[m+1]  = OVERRUN;
      if (m + 1 == rst_at) begin
        #2 RST = 1'b0;
        IN_DATA_VLD = 1'b0;
        #1;
        rs_txd = GMII_TXD; rs_en = GMII_TX_EN; rs_er = GMII_TX_ER;
        rs_done = FRAME_DONE; rs_ovr = OVERRUN; rs_rdy = TX_READY;
        return;
      end
    end
    IN_DATA_VLD = 1'b0;
  endtask

  task automatic test_crc_unit();
    string s;
    logic [31:0] c;
    s = "123456789";
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 9; i++) begin
      u_crc_in = c;
      u_data   = s[i];
      #1;
      c = u_crc_out;
    end
    n_chk++; if (~c !== 32'hCBF43926) begin n_fail++; $display("FAIL crc_check: got %h want cbf43926", ~c); end
  endtask

  task automatic test_reset();
    RST = 1'b0;
    IN_DATA_VLD = 1'b0;
    repeat (2) @(negedge CLK);
    n_chk++; if (GMII_TXD !== 8'h00)   begin n_fail++; $display("FAIL rst_txd: got %h want 00", GMII_TXD); end
    n_chk++; if (GMII_TX_EN !== 1'b0)  begin n_fail++; $display("FAIL rst_en: got %b want 0", GMII_TX_EN); end
    n_chk++; if (GMII_TX_ER !== 1'b0)  begin n_fail++; $display("FAIL rst_er: got %b want 0", GMII_TX_ER); end
    n_chk++; if (FRAME_DONE !== 1'b0)  begin n_fail++; $display("FAIL rst_done: got %b want 0", FRAME_DONE); end
    n_chk++; if (OVERRUN !== 1'b0)     begin n_fail++; $display("FAIL rst_ovr: got %b want 0", OVERRUN); end
    n_chk++; if (TX_READY !== 1'b1)    begin n_fail++; $display("FAIL rst_rdy: got %b want 1", TX_READY); end
    RST = 1'b1;
    @(negedge CLK);
    n_chk++; if (TX_READY !== 1'b1)    begin n_fail++; $display("FAIL post_rst_rdy: got %b want 1", TX_READY); end
    n_chk++; if (GMII_TX_EN !== 1'b0)  begin n_fail++; $display("FAIL post_rst_en: got %b want 0", GMII_TX_EN); end
  endtask

  // 42-byte ARP broadcast: 18 pad bytes, FCS at t+69..t+72, done at t+85.
  task automatic test_arp();
    logic [7:0]  body [0:59];
    logic [31:0] c, fcs;
    logic        e_en;
    logic [7:0]  e_txd;
    clear_in();
    for (int k = 0; k < 42; k++) begin
      in_v[k] = 1'b1;
      if (k < 6)        in_dat[k] = 8'hFF;
      else if (k < 12)  in_dat[k] = 8'(8'h10 + k);
      else if (k == 12) in_dat[k] = 8'h08;
      else if (k == 13) in_dat[k] = 8'h06;
      else              in_dat[k] = 8'(k * 7 + 3);
    end
    run_seq(95, -1);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 60; k++) begin
      body[k] = (k < 42) ? in_dat[k] : 8'h00;
      c = crc_upd(c, body[k]);
    end
    fcs = ~c;
    for (int m = 1; m < 95; m++) begin
      e_en = (m <= 72);
      if (m <= 7)       e_txd = 8'h55;
      else if (m == 8)  e_txd = 8'hD5;
      else if (m <= 68) e_txd = body[m-9];
      else if (m <= 72) e_txd = fcs[8*(m-69) +: 8];
      else              e_txd = 8'h00;
      n_chk++; if (cap_en[m] !== e_en) begin n_fail++; $display("FAIL arp_en[%0d]: got %b want %b", m, cap_en[m], e_en); end
      if (e_en) begin
        n_chk++; if (cap_txd[m] !== e_txd) begin n_fail++; $display("FAIL arp_txd[%0d]: got %h want %h", m, cap_txd[m], e_txd); end
      end
      n_chk++; if (cap_er[m] !== 1'b0) begin n_fail++; $display("FAIL arp_er[%0d]: got %b want 0", m, cap_er[m]); end
      n_chk++; if (cap_done[m] !== (m == 85)) begin n_fail++; $display("FAIL arp_done[%0d]: got %b want %b", m, cap_done[m], (m == 85)); end
      n_chk++; if (cap_rdy[m] !== (m >= 85)) begin n_fail++; $display("FAIL arp_rdy[%0d]: got %b want %b", m, cap_rdy[m], (m >= 85)); end
    end
    c = 32'hFFFFFFFF;
    for (int m = 9; m <= 72; m++) c = crc_upd(c, cap_txd[m]);
    n_chk++; if (c !== CRC_RESIDUE) begin n_fail++; $display("FAIL arp_residue: got %h want %h", c, CRC_RESIDUE); end
  endtask

  // 100-byte frame: no pad, TX_EN high for exactly 112 cycles, ready at t+125.
  task automatic test_long();
    logic [31:0] c, fcs;
    logic [7:0]  e_txd;
    int          ones;
    clear_in();
    for (int k = 0; k < 100; k++) begin in_v[k] = 1'b1; in_dat[k] = 8'(k * 13 + 5); end
    run_seq(130, -1);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 100; k++) c = crc_upd(c, in_dat[k]);
    fcs = ~c;
    ones = 0;
    for (int m = 1; m < 130; m++) begin
      if (cap_en[m] === 1'b1) ones++;
      n_chk++; if (cap_en[m] !== (m <= 112)) begin n_fail++; $display("FAIL long_en[%0d]: got %b want %b", m, cap_en[m], (m <= 112)); end
      if (m >= 9 && m <= 112) begin
        e_txd = (m <= 108) ? in_dat[m-9] : fcs[8*(m-109) +: 8];
        n_chk++; if (cap_txd[m] !== e_txd) begin n_fail++; $display("FAIL long_txd[%0d]: got %h want %h", m, cap_txd[m], e_txd); end
      end
      n_chk++; if (cap_rdy[m] !== (m >= 125)) begin n_fail++; $display("FAIL long_rdy[%0d]: got %b want %b", m, cap_rdy[m], (m >= 125)); end
      n_chk++; if (cap_done[m] !== (m == 125)) begin n_fail++; $display("FAIL long_done[%0d]: got %b want %b", m, cap_done[m], (m == 125)); end
    end
    n_chk++; if (ones != 112) begin n_fail++; $display("FAIL long_en_cycles: got %0d want 112", ones); end
    c = 32'hFFFFFFFF;
    for (int m = 9; m <= 112; m++) c = crc_upd(c, cap_txd[m]);
    n_chk++; if (c !== CRC_RESIDUE) begin n_fail++; $display("FAIL long_residue: got %h want %h", c, CRC_RESIDUE); end
  endtask

  // Frame B rises during A's IFG and stays high into IDLE: one OVERRUN, nothing sent.
  task automatic test_back_to_back();
    logic [31:0] c;
    clear_in();
    for (int k = 0; k < 60; k++)  begin in_v[k] = 1'b1; in_dat[k] = 8'(k + 1); end
    for (int k = 75; k < 91; k++) begin in_v[k] = 1'b1; in_dat[k] = 8'hEE; end
    run_seq(140, -1);
    for (int m = 1; m < 140; m++) begin
      n_chk++; if (cap_ovr[m] !== (m == 76)) begin n_fail++; $display("FAIL b2b_ovr[%0d]: got %b want %b", m, cap_ovr[m], (m == 76)); end
      n_chk++; if (cap_en[m] !== (m <= 72)) begin n_fail++; $display("FAIL b2b_en[%0d]: got %b want %b", m, cap_en[m], (m <= 72)); end
      n_chk++; if (cap_done[m] !== (m == 85)) begin n_fail++; $display("FAIL b2b_done[%0d]: got %b want %b", m, cap_done[m], (m == 85)); end
      n_chk++; if (cap_rdy[m] !== (m >= 85)) begin n_fail++; $display("FAIL b2b_rdy[%0d]: got %b want %b", m, cap_rdy[m], (m >= 85)); end
    end
    clear_in();
    for (int k = 0; k < 64; k++) begin in_v[k] = 1'b1; in_dat[k] = 8'(8'hC0 ^ k); end
    run_seq(95, -1);
    for (int m = 1; m <= 8; m++) begin
      n_chk++; if (cap_txd[m] !== ((m == 8) ? 8'hD5 : 8'h55)) begin n_fail++; $display("FAIL next_pre[%0d]: got %h want %h", m, cap_txd[m], ((m == 8) ? 8'hD5 : 8'h55)); end
    end
    for (int m = 9; m <= 72; m++) begin
      n_chk++; if (cap_txd[m] !== in_dat[m-9]) begin n_fail++; $display("FAIL next_txd[%0d]: got %h want %h", m, cap_txd[m], in_dat[m-9]); end
    end
    c = 32'hFFFFFFFF;
    for (int m = 9; m <= 76; m++) c = crc_upd(c, cap_txd[m]);
    n_chk++; if (c !== CRC_RESIDUE) begin n_fail++; $display("FAIL next_residue: got %h want %h", c, CRC_RESIDUE); end
    n_chk++; if (cap_done[89] !== 1'b1) begin n_fail++; $display("FAIL next_done: got %b want 1", cap_done[89]); end
    n_chk++; if (cap_en[77] !== 1'b0) begin n_fail++; $display("FAIL next_en_off: got %b want 0", cap_en[77]); end
  endtask

  // 1520-byte frame: bytes 1515..1520 and all FCS bytes carry TX_ER.
  task automatic test_oversize();
    logic [31:0] c, fcs;
    logic [7:0]  e_txd;
    logic        e_er;
    int          ers;
    clear_in();
    for (int k = 0; k < 1520; k++) begin in_v[k] = 1'b1; in_dat[k] = 8'(k ^ (k >> 8)); end
    run_seq(1550, -1);
    c = 32'hFFFFFFFF;
    for (int k = 0; k < 1520; k++) c = crc_upd(c, in_dat[k]);
    fcs = ~c;
    ers = 0;
    for (int m = 1; m < 1550; m++) begin
      if (cap_er[m] === 1'b1) ers++;
      e_er = (m >= 9 + 1514) && (m <= 1532);
      n_chk++; if (cap_er[m] !== e_er) begin n_fail++; $display("FAIL big_er[%0d]: got %b want %b", m, cap_er[m], e_er); end
      n_chk++; if (cap_en[m] !== (m <= 1532)) begin n_fail++; $display("FAIL big_en[%0d]: got %b want %b", m, cap_en[m], (m <= 1532)); end
      if (m >= 9 && m <= 1532) begin
        e_txd = (m <= 1528) ? in_dat[m-9] : fcs[8*(m-1529) +: 8];
        n_chk++; if (cap_txd[m] !== e_txd) begin n_fail++; $display("FAIL big_txd[%0d]: got %h want %h", m, cap_txd[m], e_txd); end
      end
    end
    n_chk++; if (ers != 10) begin n_fail++; $display("FAIL big_er_count: got %0d want 10", ers); end
    n_chk++; if (cap_done[1545] !== 1'b1) begin n_fail++; $display("FAIL big_done: got %b want 1", cap_done[1545]); end
  endtask

  // Reset while data byte 30 is on the wire, then a clean frame afterwards.
  task automatic test_reset_mid();
    clear_in();
    for (int k = 0; k < 60; k++) begin in_v[k] = 1'b1; in_dat[k] = 8'(8'h30 + k); end
    run_seq(60, 39);
    n_chk++; if (cap_txd[39] !== in_dat[30]) begin n_fail++; $display("FAIL mid_byte30: got %h want %h", cap_txd[39], in_dat[30]); end
    n_chk++; if (rs_txd !== 8'h00) begin n_fail++; $display("FAIL mid_rst_txd: got %h want 00", rs_txd); end
    n_chk++; if (rs_en !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_en: got %b want 0", rs_en); end
    n_chk++; if (rs_er !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_er: got %b want 0", rs_er); end
    n_chk++; if (rs_done !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done: got %b want 0", rs_done); end
    n_chk++; if (rs_ovr !== 1'b0)  begin n_fail++; $display("FAIL mid_rst_ovr: got %b want 0", rs_ovr); end
    n_chk++; if (rs_rdy !== 1'b1)  begin n_fail++; $display("FAIL mid_rst_rdy: got %b want 1", rs_rdy); end
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_chk++; if (TX_READY !== 1'b1) begin n_fail++; $display("FAIL mid_rel_rdy: got %b want 1", TX_READY); end
    clear_in();
    for (int k = 0; k < 60; k++) begin in_v[k] = 1'b1; in_dat[k] = 8'(8'h90 + k); end
    run_seq(30, -1);
    for (int m = 1; m < 30; m++) begin
      n_chk++; if (cap_en[m] !== 1'b1) begin n_fail++; $display("FAIL mid_next_en[%0d]: got %b want 1", m, cap_en[m]); end
      if (m <= 8) begin
        n_chk++; if (cap_txd[m] !== ((m == 8) ? 8'hD5 : 8'h55)) begin n_fail++; $display("FAIL mid_next_pre[%0d]: got %h want %h", m, cap_txd[m], ((m == 8) ? 8'hD5 : 8'h55)); end
      end else begin
        n_chk++; if (cap_txd[m] !== in_dat[m-9]) begin n_fail++; $display("FAIL mid_next_txd[%0d]: got %h want %h", m, cap_txd[m], in_dat[m-9]); end
      end
    end
  endtask

  initial begin
    test_crc_unit();
    @(negedge CLK);
    test_reset();
    test_arp();
    test_long();
    test_back_to_back();
    test_oversize();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
